// File: rtl/spi_flash_loader.sv
// rtl/spi_flash_loader.sv - boot loader: SPI-flash READ streamed into RAM via spi register port
module spi_flash_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter logic [22:0] MEM_BASE   = 23'h000000,
  parameter logic [15:0] LOAD_WORDS = 16'd1024,
  parameter logic [2:0]  CLK_DIV    = 3'd2,
  parameter logic [2:0]  CS_SEL     = 3'd1,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] spi_data_write,
  input  logic [15:0] spi_data_read,
  output logic [7:0]  spi_addr,
  output logic        spi_uds,
  output logic        spi_lds,
  output logic        spi_rw,
  input  logic        spi_ack,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] REG_TX   = 8'd2;
  localparam logic [7:0] REG_CTRL = 8'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_CMD, S_AD2, S_AD1, S_AD0,
    S_DTX, S_DRX, S_MWR, S_CS_OFF, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        rx_q, rx_d;        // header states: 0 = tx pending, 1 = discard rx pending
  logic        phase_q, phase_d;  // 0 = next data byte is the high byte of a word
  logic [7:0]  hi_q, hi_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  spi_addr_q, spi_addr_d;
  logic [15:0] spi_wdata_q, spi_wdata_d;
  logic        spi_rw_q, spi_rw_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;

  logic        xact;
  logic [7:0]  x_addr;
  logic        x_rw;
  logic [15:0] x_data;
  logic        tmo_hit;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^spi_data_read[15:8];
  assign tmo_hit = ({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT};

  // Register access the current state wants to issue (addr, direction, data)
  always_comb begin
    xact   = 1'b0;
    x_addr = REG_TX;
    x_rw   = 1'b0;
    x_data = 16'h0000;
    case (state_q)
      S_CS_ON: begin
        xact   = 1'b1;
        x_addr = REG_CTRL;
        x_data = {9'b0, CS_SEL, CLK_DIV, 1'b0};
      end
      S_CS_OFF: begin
        xact   = 1'b1;
        x_addr = REG_CTRL;
        x_data = {9'b0, 3'b000, CLK_DIV, 1'b0};
      end
      S_CMD: begin
        xact = 1'b1; x_rw = rx_q; x_data = 16'h0003;
      end
      S_AD2: begin
        xact = 1'b1; x_rw = rx_q; x_data = {8'h00, FLASH_ADDR[23:16]};
      end
      S_AD1: begin
        xact = 1'b1; x_rw = rx_q; x_data = {8'h00, FLASH_ADDR[15:8]};
      end
      S_AD0: begin
        xact = 1'b1; x_rw = rx_q; x_data = {8'h00, FLASH_ADDR[7:0]};
      end
      S_DTX: xact = 1'b1;
      S_DRX: begin
        xact = 1'b1; x_rw = 1'b1;
      end
      default: xact = 1'b0;
    endcase
  end

  // Next-state logic: issue, wait for ack (with timeout), then advance
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rx_d        = rx_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    spi_rw_d    = spi_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = mem_we_q;
    case (state_q)
      // IDLE is only occupied right after reset, so leaving it is the auto-start
      S_IDLE: begin
        state_d = S_CS_ON;
        req_d = 1'b0; rx_d = 1'b0; phase_d = 1'b0; cnt_d = 16'd0;
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_CS_ON;
          req_d = 1'b0; rx_d = 1'b0; phase_d = 1'b0; cnt_d = 16'd0;
        end
      end
      S_MWR: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
          cnt_d    = cnt_q + 16'd1;
          state_d  = (cnt_q + 16'd1 == LOAD_WORDS) ? S_CS_OFF : S_DTX;
        end else if (tmo_hit) begin
          mem_we_d = 1'b0;
          state_d  = S_ERROR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        if (xact) begin
          if (!req_q) begin
            // req low here also provides the idle cycle between accesses
            req_d       = 1'b1;
            tmo_d       = 16'd0;
            spi_addr_d  = x_addr;
            spi_rw_d    = x_rw;
            spi_wdata_d = x_data;
          end else if (spi_ack) begin
            req_d = 1'b0;
            case (state_q)
              S_CS_ON:  begin state_d = S_CMD; rx_d = 1'b0; end
              S_CMD:    begin rx_d = ~rx_q; if (rx_q) state_d = S_AD2; end
              S_AD2:    begin rx_d = ~rx_q; if (rx_q) state_d = S_AD1; end
              S_AD1:    begin rx_d = ~rx_q; if (rx_q) state_d = S_AD0; end
              S_AD0:    begin rx_d = ~rx_q; if (rx_q) state_d = S_DTX; end
              S_DTX:    state_d = S_DRX;
              S_DRX: begin
                if (!phase_q) begin
                  hi_d    = spi_data_read[7:0];
                  phase_d = 1'b1;
                  state_d = S_DTX;
                end else begin
                  phase_d    = 1'b0;
                  mem_data_d = {hi_q, spi_data_read[7:0]};
                  mem_addr_d = MEM_BASE + {7'b0, cnt_q};
                  mem_we_d   = 1'b1;
                  tmo_d      = 16'd0;
                  state_d    = S_MWR;
                end
              end
              S_CS_OFF: state_d = S_DONE;
              default:  state_d = state_q;
            endcase
          end else if (tmo_hit) begin
            // chip select is deliberately left as-is; recovery is by reset
            req_d   = 1'b0;
            state_d = S_ERROR;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      rx_q        <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= 8'h00;
      cnt_q       <= 16'd0;
      tmo_q       <= 16'd0;
      spi_addr_q  <= 8'h00;
      spi_wdata_q <= 16'h0000;
      spi_rw_q    <= 1'b0;
      mem_addr_q  <= 23'h0;
      mem_data_q  <= 16'h0000;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rx_q        <= rx_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
      spi_rw_q    <= spi_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign spi_lds        = req_q & ~spi_ack;
  assign spi_uds        = 1'b0;
  assign spi_addr       = spi_addr_q;
  assign spi_data_write = spi_wdata_q;
  assign spi_rw         = spi_rw_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data       = mem_data_q;
  assign mem_we         = mem_we_q;
  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_ERROR);

endmodule

// File: tb/tb_spi_flash_loader.sv
// tb/tb_spi_flash_loader.sv - scoreboard bench for spi_flash_loader with spi and RAM models
module tb_spi_flash_loader;

  localparam logic [15:0] TMO = 16'd40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] spi_data_write;
  logic [15:0] spi_data_read = 16'h0000;
  logic [7:0]  spi_addr;
  logic        spi_uds, spi_lds, spi_rw;
  logic        spi_ack = 1'b0;
  logic [22:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        mem_ack = 1'b0;
  logic        busy, done, error;

  spi_flash_loader #(
    .FLASH_ADDR(24'hABCDEF), .MEM_BASE(23'h7FFFFE), .LOAD_WORDS(16'd4),
    .CLK_DIV(3'd2), .CS_SEL(3'd1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .spi_data_write(spi_data_write), .spi_data_read(spi_data_read),
    .spi_addr(spi_addr), .spi_uds(spi_uds), .spi_lds(spi_lds), .spi_rw(spi_rw),
    .spi_ack(spi_ack), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ack(mem_ack), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [40:0] exp_q[$];

  int   mem_delay = 0;
  int   mem_seen = 0;
  bit   kill_after_cmd = 0;
  bit   kill = 0;
  logic [2:0] cs_n = 3'b111;

  always @(posedge clk) cyc++;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_event(input logic [1:0] k, input logic [22:0] a, input logic [15:0] d);
    logic [40:0] act;
    logic [40:0] exp;
    act = {k, a, d};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got %0h expected no event (cycle %0d)", act, cyc);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL sb_event: got %0h expected %0h (cycle %0d)", act, exp, cyc);
      end
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [22:0] a, input logic [15:0] d);
    exp_q.push_back({k, a, d});
  endtask

  // kind 0 = spi write, 1 = spi read, 2 = RAM write
  task automatic push_load();
    logic [7:0]  hdr [4];
    logic [22:0] wa [4];
    logic [15:0] wd [4];
    hdr = '{8'h03, 8'hAB, 8'hCD, 8'hEF};
    wa  = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
    wd  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    push_ev(2'd0, 23'd6, 16'h0014);
    for (int i = 0; i < 4; i++) begin
      push_ev(2'd0, 23'd2, {8'h00, hdr[i]});
      push_ev(2'd1, 23'd2, 16'h0000);
    end
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 2; b++) begin
        push_ev(2'd0, 23'd2, 16'h0000);
        push_ev(2'd1, 23'd2, 16'h0000);
      end
      push_ev(2'd2, wa[w], wd[w]);
    end
    push_ev(2'd0, 23'd6, 16'h0004);
  endtask

  // spi peripheral model: immediate ack except rx while a byte shifts
  logic [7:0] flash_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  int         tx_idx = 0;
  int         shift_cnt = 0;
  logic [7:0] miso = 8'hFF;
  logic [2:0] cs_val;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      spi_ack = 1'b0; shift_cnt = 0; cs_n = 3'b111; kill = 0;
    end else begin
      if (shift_cnt > 0) shift_cnt--;
      if (spi_ack) begin
        spi_ack = 1'b0;
      end else if (spi_lds && !kill) begin
        if (!(spi_addr == 8'd2 && shift_cnt != 0)) begin
          spi_ack = 1'b1;
          if (spi_rw) begin
            spi_data_read = {8'h00, miso};
            check_event(2'd1, {15'b0, spi_addr}, 16'h0000);
          end else begin
            check_event(2'd0, {15'b0, spi_addr}, spi_data_write);
            if (spi_addr == 8'd6) begin
              cs_val = spi_data_write[6:4];
              cs_n = ~((cs_val == 3'd1) ? 3'b001 : (cs_val == 3'd2) ? 3'b010 :
                       (cs_val == 3'd3) ? 3'b100 : 3'b000);
              if (cs_val != 3'd0) tx_idx = 0;
            end else if (spi_addr == 8'd2) begin
              miso = (tx_idx < 4 || tx_idx > 11) ? 8'hFF : flash_bytes[tx_idx-4];
              tx_idx++;
              shift_cnt = 8;
              if (kill_after_cmd && tx_idx == 1) kill = 1;
            end
          end
        end
      end
    end
  end

  // RAM model: ack after mem_delay stalled cycles, checking hold stability
  int          stall = 0;
  logic [22:0] lat_a;
  logic [15:0] lat_d;
  bit          stable_ok;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      mem_ack = 1'b0; stall = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      cmp("mem_we_drop", {31'b0, mem_we}, 32'd0);
    end else if (mem_we) begin
      if (stall == 0) begin
        lat_a = mem_addr; lat_d = mem_data; stable_ok = 1;
      end else if (mem_addr !== lat_a || mem_data !== lat_d || spi_lds !== 1'b0) begin
        stable_ok = 0;
      end
      if (stall >= mem_delay) begin
        mem_ack = 1'b1;
        stall = 0;
        if (mem_delay > 0) cmp("mem_stall_stable", {31'b0, stable_ok}, 32'd1);
        cmp("cs_during_load", {29'b0, cs_n}, 32'h6);
        check_event(2'd2, mem_addr, mem_data);
        mem_seen++;
      end else begin
        stall++;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_flag(input string nm, input bit want_err);
    int n;
    n = 0;
    while (!(want_err ? error : done) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    cmp(nm, {31'b0, (want_err ? error : done)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    cmp({nm, "_ctl"}, {24'b0, busy, done, error, spi_lds, spi_uds, spi_rw, mem_we, 1'b0}, 32'd0);
    cmp({nm, "_spi"}, {8'b0, spi_addr, spi_data_write}, 32'd0);
    cmp({nm, "_mem"}, {mem_addr, 9'b0} | {16'b0, mem_data}, 32'd0);
  endtask

  initial begin
    int t0, t1, n;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // auto-start, start pulse while busy ignored, full load with wrap
    push_load();
    reset = 1'b0;
    @(negedge clk);
    cmp("autostart_busy", {31'b0, busy}, 32'd1);
    cmp("autostart_no_req", {31'b0, spi_lds}, 32'd0);
    @(negedge clk);
    cmp("autostart_req", {23'b0, spi_lds, spi_addr}, {23'b0, 1'b1, 8'd6});
    repeat (60) @(negedge clk);
    pulse_start();
    wait_flag("load1_done", 1'b0);
    cmp("load1_flags", {29'b0, busy, done, error}, 32'b010);
    cmp("load1_cs_off", {29'b0, cs_n}, 32'h7);
    cmp("load1_drained", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    cmp("done_sticky", {31'b0, done}, 32'd1);

    // memory stall
    mem_delay = 5;
    push_load();
    pulse_start();
    cmp("restart_flags", {29'b0, busy, done, error}, 32'b100);
    wait_flag("stall_done", 1'b0);
    cmp("stall_drained", exp_q.size(), 32'd0);
    mem_delay = 0;

    // timeout after the command byte
    kill_after_cmd = 1;
    push_ev(2'd0, 23'd6, 16'h0014);
    push_ev(2'd0, 23'd2, 16'h0003);
    pulse_start();
    n = 0;
    while (!(kill && spi_lds) && n < 2000) begin @(negedge clk); n++; end
    cmp("tmo_req_seen", {31'b0, spi_lds}, 32'd1);
    t0 = cyc;
    wait_flag("tmo_error", 1'b1);
    t1 = cyc;
    cmp("tmo_latency", t1 - t0, {16'b0, TMO});
    cmp("tmo_flags", {28'b0, busy, done, spi_lds, mem_we}, 32'd0);
    cmp("tmo_drained", exp_q.size(), 32'd0);

    // rerun after error
    kill_after_cmd = 0;
    kill = 0;
    push_load();
    pulse_start();
    cmp("err_cleared", {29'b0, busy, done, error}, 32'b100);
    wait_flag("rerun_done", 1'b0);
    cmp("rerun_drained", exp_q.size(), 32'd0);

    // reset during word 3, then auto-restart from MEM_BASE
    push_load();
    mem_seen = 0;
    pulse_start();
    n = 0;
    while (mem_seen < 2 && n < 4000) begin @(negedge clk); n++; end
    cmp("mid_words_seen", mem_seen, 32'd2);
    n = 0;
    while (!spi_lds && n < 200) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    push_load();
    @(negedge clk);
    reset = 1'b0;
    wait_flag("midreset_done", 1'b0);
    cmp("midreset_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
